// File: rtl/mp_addsub_seq.sv
// Multi-precision add/subtract sequencer: streams 32-bit slices, LSB first, through one
// shared ripple-carry adder, then presents result, carry/borrow and signed overflow.

module sumator_32 (
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        cin,
    output logic [31:0] s,
    output logic        cout
);
    logic cy;

    // A scalar carry walked through the loop keeps the ripple chain free of
    // self-referencing vector bits.
    always_comb begin
        cy = cin;
        s  = '0;
        for (int i = 0; i < 32; i++) begin
            s[i] = a[i] ^ b[i] ^ cy;
            cy   = (a[i] & b[i]) | (cy & (a[i] ^ b[i]));
        end
        cout = cy;
    end
endmodule

module mp_addsub_seq #(
    parameter int unsigned WORDS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  op_sub,
    input  logic [32*WORDS-1:0]   op_a,
    input  logic [32*WORDS-1:0]   op_b,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [32*WORDS-1:0]   res,
    output logic                  carry,
    output logic                  ovf,
    output logic                  busy
);
    localparam int unsigned W  = 32 * WORDS;
    localparam int unsigned CW = $clog2(WORDS);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    state_e          state_q, state_d;
    logic [W-1:0]    a_q, b_q, res_q;
    logic            sub_q;
    logic            cy_q;
    logic            carry_q, ovf_q;
    logic [CW-1:0]   cnt_q;

    logic [31:0]     slice_a, slice_b, sum;
    logic            cout;
    logic            last;

    assign last    = (cnt_q == CW'(WORDS - 1));
    assign slice_a = a_q[32*cnt_q +: 32];
    assign slice_b = b_q[32*cnt_q +: 32] ^ {32{sub_q}};

    sumator_32 u_add (
        .a    (slice_a),
        .b    (slice_b),
        .cin  (cy_q),
        .s    (sum),
        .cout (cout)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (in_valid) state_d = StRun;
            StRun:  if (last) state_d = StDone;
            StDone: if (out_ready) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            cy_q    <= 1'b0;
            cnt_q   <= '0;
            res_q   <= '0;
            carry_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            unique case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        a_q   <= op_a;
                        b_q   <= op_b;
                        sub_q <= op_sub;
                        // Subtraction is A + ~B + 1; the +1 enters as the first carry-in.
                        cy_q  <= op_sub;
                        cnt_q <= '0;
                    end
                end
                StRun: begin
                    res_q[32*cnt_q +: 32] <= sum;
                    cy_q                  <= cout;
                    if (last) begin
                        carry_q <= cout;
                        ovf_q   <= (slice_a[31] == slice_b[31]) && (sum[31] != slice_a[31]);
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign in_ready  = (state_q == StIdle);
    assign out_valid = (state_q == StDone);
    assign busy      = (state_q == StRun);
    assign res       = res_q;
    assign carry     = carry_q;
    assign ovf       = ovf_q;
endmodule

// File: tb/tb_mp_addsub_seq.sv
// Scoreboard bench for mp_addsub_seq (WORDS=4): directed vectors plus a randomised
// regression against an arithmetic reference model.

module tb_mp_addsub_seq;
    localparam int WORDS = 4;
    localparam int W     = 128;

    typedef struct {
        logic [W-1:0] res;
        logic         c;
        logic         o;
    } exp_t;

    logic           clk = 1'b0;
    logic           rst;
    logic           in_valid;
    logic           in_ready;
    logic           op_sub;
    logic [W-1:0]   op_a, op_b;
    logic           out_valid;
    logic           out_ready;
    logic [W-1:0]   res;
    logic           carry, ovf, busy;

    int   n_pass  = 0;
    int   n_total = 0;
    int   cyc     = 0;
    bit   rand_rdy = 0;
    exp_t sbq[$];

    mp_addsub_seq #(.WORDS(WORDS)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op_sub    (op_sub),
        .op_a      (op_a),
        .op_b      (op_b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .res       (res),
        .carry     (carry),
        .ovf       (ovf),
        .busy      (busy)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(string nm, logic [W-1:0] act, logic [W-1:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    endfunction

    function automatic exp_t mk(logic [W-1:0] r, logic c, logic o);
        exp_t e;
        e.res = r;
        e.c   = c;
        e.o   = o;
        return e;
    endfunction

    // Independent reference: wide unsigned result, unsigned compare for borrow,
    // sign-extended arithmetic for overflow.
    function automatic exp_t model(bit sub, logic [W-1:0] a, logic [W-1:0] b);
        exp_t m;
        logic [W:0]        u;
        logic signed [W:0] sa, sb, s;
        sa = {a[W-1], a};
        sb = {b[W-1], b};
        if (!sub) begin
            u   = {1'b0, a} + {1'b0, b};
            s   = sa + sb;
            m.c = u[W];
        end else begin
            u   = {1'b0, a} - {1'b0, b};
            s   = sa - sb;
            m.c = (a >= b);
        end
        m.res = u[W-1:0];
        m.o   = (s[W] != s[W-1]);
        return m;
    endfunction

    function automatic logic [W-1:0] rnd_op();
        logic [W-1:0] v;
        for (int w = 0; w < WORDS; w++) begin
            case ($urandom_range(0, 5))
                0:       v[32*w +: 32] = 32'h0000_0000;
                1:       v[32*w +: 32] = 32'hFFFF_FFFF;
                2:       v[32*w +: 32] = 32'h8000_0000;
                3:       v[32*w +: 32] = 32'h7FFF_FFFF;
                default: v[32*w +: 32] = $urandom;
            endcase
        end
        return v;
    endfunction

    // Called at posedge+1; returns the cycle number of the accepting edge.
    task automatic issue(input bit sub, input logic [W-1:0] a, input logic [W-1:0] b,
                         input exp_t e, input bit push, output int acc);
        int n = 0;
        if (push) sbq.push_back(e);
        op_sub   = sub;
        op_a     = a;
        op_b     = b;
        in_valid = 1'b1;
        forever begin
            @(negedge clk);
            if (in_ready) break;
            n++;
            if (n > 200) begin
                chk("accept_timeout", 0, 1);
                break;
            end
        end
        @(posedge clk);
        #1;
        acc      = cyc;
        in_valid = 1'b0;
        op_sub   = $urandom_range(0, 1);
        op_a     = rnd_op();
        op_b     = rnd_op();
    endtask

    task automatic wait_valid(output int t);
        int n = 0;
        forever begin
            @(negedge clk);
            if (out_valid) break;
            n++;
            if (n > 100) begin
                chk("valid_timeout", 0, 1);
                break;
            end
        end
        t = cyc;
    endtask

    // Monitor: every output handshake pops and checks the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!rst && out_valid && out_ready) begin
                if (sbq.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                end else begin
                    e = sbq.pop_front();
                    chk("res", res, e.res);
                    chk("carry", W'(carry), W'(e.c));
                    chk("ovf", W'(ovf), W'(e.o));
                end
            end
        end
    end

    initial begin
        @(posedge clk);
        forever begin
            @(posedge clk);
            #1;
            if (rand_rdy) out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc, t, n;
        bit s;
        logic [W-1:0] a, b;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        op_sub = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_in_ready", W'(in_ready), 1);
        chk("rst_out_valid", W'(out_valid), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_res", res, 0);
        chk("rst_carry", W'(carry), 0);
        chk("rst_ovf", W'(ovf), 0);
        @(posedge clk);
        #1;

        // Carry ripples from slice 0 into slice 1; also measures latency.
        issue(0, 128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 128'h1,
              mk(128'h0000_0000_0000_0000_0000_0001_0000_0000, 0, 0), 1, acc);
        wait_valid(t);
        chk("latency", W'(t - acc), 4);
        @(posedge clk);
        #1;

        issue(0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1,
              mk(128'h0, 1, 0), 1, acc);
        issue(1, 128'h0, 128'h1,
              mk(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 0, 0), 1, acc);
        issue(0, 128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h1,
              mk(128'h8000_0000_0000_0000_0000_0000_0000_0000, 0, 1), 1, acc);
        issue(1, 128'h8000_0000_0000_0000_0000_0000_0000_0000, 128'h1,
              mk(128'h7FFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 1, 1), 1, acc);

        // Backpressure: result held in DONE while a second command waits.
        issue(0, 128'h0000_0001_0000_0002_0000_0003_0000_0004,
              128'h1000_0000_2000_0000_3000_0000_4000_0000,
              mk(128'h1000_0001_2000_0002_3000_0003_4000_0004, 0, 0), 1, acc);
        out_ready = 1'b0;
        wait_valid(t);
        @(posedge clk);
        #1;
        sbq.push_back(mk(128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFE, 0, 0));
        op_sub = 1'b1; op_a = 128'h5; op_b = 128'h7; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("bp_out_valid", W'(out_valid), 1);
            chk("bp_in_ready", W'(in_ready), 0);
            chk("bp_res", res, 128'h1000_0001_2000_0002_3000_0003_4000_0004);
        end
        @(posedge clk);
        #1 out_ready = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("bp_release_in_ready", W'(in_ready), 1);
        chk("bp_release_out_valid", W'(out_valid), 0);
        @(posedge clk);
        #1 in_valid = 1'b0;
        @(negedge clk);
        chk("bp_queued_busy", W'(busy), 1);
        @(posedge clk);
        #1;

        // Reset while the slice counter is at 2.
        issue(0, 128'hFFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF_FFFF, 128'h3, mk(0, 0, 0), 0, acc);
        @(posedge clk);
        @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_in_ready", W'(in_ready), 1);
        chk("mid_rst_out_valid", W'(out_valid), 0);
        chk("mid_rst_busy", W'(busy), 0);
        chk("mid_rst_res", res, 0);
        @(posedge clk);
        #1;
        issue(1, 128'h0000_0000_0000_0000_0000_0001_0000_0000, 128'h1,
              mk(128'h0000_0000_0000_0000_0000_0000_FFFF_FFFF, 1, 0), 1, acc);

        rand_rdy = 1;
        for (int i = 0; i < 1000; i++) begin
            s = 1'($urandom_range(0, 1));
            a = rnd_op();
            b = rnd_op();
            issue(s, a, b, model(s, a, b), 1, acc);
        end
        rand_rdy = 0;
        @(posedge clk);
        #2 out_ready = 1'b1;

        n = 0;
        while (sbq.size() != 0 && n < 200) begin
            @(posedge clk);
            n++;
        end
        chk("drain", W'(sbq.size()), 0);
        repeat (2) @(posedge clk);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/mp_addsub_seq.md
Name: mp_addsub_seq

Overview:
- Multi-precision add/subtract sequencer around one shared 32-bit ripple-carry adder instance (sumator_32).
- Takes WORDS×32-bit operands through a valid/ready handshake and feeds one 32-bit slice per cycle to the adder, least significant slice first.
- Carries the inter-slice carry in a register.
- Returns the full result with carry/borrow and signed overflow on a valid/ready output handshake.

Parameters:
- WORDS, 4, number of 32-bit slices per operand (operand width = 32*WORDS); legal range 2..16.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  operand/command valid.
- in_ready  output  1  block can accept a command.
- op_sub  input  1  0 = A+B, 1 = A−B; sampled at accept.
- op_a  input  32*WORDS  operand A; sampled at accept.
- op_b  input  32*WORDS  operand B; sampled at accept.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- res  output  32*WORDS  sum/difference, modulo 2^(32*WORDS).
- carry  output  1  add: carry out of the MSB; sub: 1 = no borrow (A ≥ B unsigned).
- ovf  output  1  two's-complement signed overflow.
- busy  output  1  high in RUN.

Behaviour:
- Reset (rst=1 at a clock edge, any state):
  - state ← IDLE; in_ready=1; out_valid=0; busy=0.
  - res, carry and ovf ← 0; slice counter ← 0; carry register ← 0.
  - Reset mid-RUN or mid-DONE abandons the operation; no partial result is ever presented.
- States: IDLE, RUN, DONE. in_ready = (state==IDLE).
- IDLE:
  - On in_valid & in_ready: latch op_a, op_b and op_sub.
  - Carry register ← op_sub (Cin=1 for subtraction); slice counter ← 0; → RUN.
  - in_valid without acceptance has no effect.
- RUN, each cycle with counter k:
  - Adder A = a[32k+31:32k].
  - Adder B = b slice, inverted bitwise when op_sub=1.
  - Adder Cin = carry register.
  - Adder S is written to res[32k+31:32k]; carry register ← adder Cout.
  - At k = WORDS−1:
    - carry ← adder Cout.
    - ovf ← (sA==sB')&(sS!=sA), where sA = MSB of the A slice, sB' = MSB of the post-inversion B slice, sS = MSB of S.
    - → DONE. Otherwise k ← k+1.
- DONE:
  - out_valid=1; res, carry and ovf are stable.
  - On out_ready: out_valid ← 0 and → IDLE next cycle.
  - Without out_ready, hold indefinitely.
- Latency: accept at edge E0 → out_valid high after edge E0+WORDS (WORDS RUN cycles, DONE visible in the following cycle).
- Throughput: one operation per WORDS+2 cycles minimum, since IDLE lasts ≥1 cycle between operations.
- Untouched res slices are not guaranteed during RUN; only valid with out_valid.
- Inputs op_a/op_b/op_sub may change after acceptance without affecting the operation in flight.
- Slice counter width is clog2(WORDS); it never exceeds WORDS−1.
- No combinational path from in_valid to in_ready or from out_ready to out_valid.

Test Plan:
- WORDS=4, A=0x00000000_00000000_00000000_FFFFFFFF, B=1, add:
  - res=0x...0001_00000000; carry=0; ovf=0.
  - out_valid rises exactly 4 cycles after accept.
- Add all-ones + 1 (128-bit): res=0, carry=1, ovf=0. Sub 0 − 1: res=all-ones, carry=0 (borrow), ovf=0.
- Signed overflow:
  - A=0x7FFF…FFFF + B=1 → res=0x8000…0000, ovf=1.
  - Sub 0x8000…0000 − 1 → res=0x7FFF…FFFF, ovf=1, carry=1.
- Backpressure:
  - Hold out_ready=0 for 10 cycles in DONE → outputs stable, in_ready=0; a second in_valid is not accepted.
  - Release out_ready → in_ready=1 on the next cycle; the queued command is then accepted.
- Assert rst in RUN at k=2:
  - Next cycle state IDLE, out_valid=0, res=0.
  - A fresh command afterward completes correctly with no stale carry.
- Randomised regression: 1000 ops with mixed add/sub and random out_ready, compared against a reference model for res, carry and ovf.
